ysyx_24100005_imem_resp: RTL

//   Memory responder serving the core's instruction/data read requests. Pairs with the core's fetch initiator.

---
 rtl/ysyx_24100005_imem_resp.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ysyx_24100005_imem_resp.sv
// Word-array memory responder: one outstanding read over a valid/ready request channel,
// answered LATENCY cycles after acceptance on a valid/ready response channel, plus a byte-masked write port.
module ysyx_24100005_imem_resp #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [31:0]              resp_data,
  output logic                     resp_err,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [31:0]              wr_data,
  input  logic [3:0]               wr_mask
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [32:0] SPAN     = 33'(DEPTH) * 33'd4;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  logic [31:0] mem [DEPTH];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;

  logic [31:0]   off_s;
  logic          addr_ok_s;
  logic [AW-1:0] idx_s;

  // Addresses below BASE_ADDR wrap to a huge offset and so fail the range test.
  assign off_s     = addr_q - BASE_ADDR;
  assign addr_ok_s = (addr_q[1:0] == 2'b00) && ({1'b0, off_s} < SPAN);
  assign idx_s     = off_s[AW+1:2];

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d      = req_addr;
          cnt_d       = CNT_INIT;
          state_d     = WAIT;
          req_ready_d = 1'b0;
        end else begin
          req_ready_d = 1'b1;
        end
      end
      WAIT: begin
        // Capture reads the array before any same-edge write lands, so it returns the old word.
        if (cnt_q == 4'd0) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = !addr_ok_s;
          resp_data_d  = addr_ok_s ? mem[idx_s] : 32'h0000_0000;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = IDLE;
        end else begin
          resp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d      = IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  // Control and response registers; reset drops any in-flight request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      addr_q       <= 32'h0000_0000;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'h0000_0000;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Byte-masked array write, independent of the request FSM and not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) begin
          mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

endmodule
